// File: rtl/adt7310_measure_fsm.sv
// ADT7310 one-shot measurement sequencer: configures one-shot mode, waits the
// conversion time, then reads the 16-bit temperature register over the shared SPI master.
module adt7310_measure_fsm #(
    parameter int                   DataWidth  = 8,
    parameter logic [DataWidth-1:0] CmdWrCfg   = 8'h08,
    parameter logic [DataWidth-1:0] CfgOneShot = 8'h20,
    parameter logic [DataWidth-1:0] CmdRdTemp  = 8'h50
) (
    input  logic                     Clk_i,
    input  logic                     Reset_n_i,
    input  logic                     Start_i,
    output logic                     Done_o,
    output logic [DataWidth-1:0]     Byte0_o,
    output logic [DataWidth-1:0]     Byte1_o,
    input  logic [2*DataWidth-1:0]   ParamCounterPreset_i,
    output logic                     ADT7310CS_n_o,
    output logic [DataWidth-1:0]     SPI_Data_o,
    output logic                     SPI_Write_o,
    output logic                     SPI_ReadNext_o,
    input  logic [DataWidth-1:0]     SPI_Data_i,
    input  logic                     SPI_FIFOFull_i,
    input  logic                     SPI_FIFOEmpty_i,
    input  logic                     SPI_Transmission_i
);

    localparam int TimerWidth = 2 * DataWidth;

    typedef enum logic [3:0] {
        stIdle, stWrCfg0, stWrCfg1, stWaitCfg, stDrainCfg, stConv,
        stRd0, stRd1, stRd2, stWaitRd, stPop0, stPop1, stPop2, stDone
    } state_t;

    state_t                  stateReg, stateNext;
    logic [TimerWidth-1:0]   timerReg, timerNext;
    logic                    drainCntReg, drainCntNext;
    logic [DataWidth-1:0]    byte0Reg, byte0Next;
    logic [DataWidth-1:0]    byte1Reg, byte1Next;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            stateReg    <= stIdle;
            timerReg    <= '0;
            drainCntReg <= 1'b0;
            byte0Reg    <= '0;
            byte1Reg    <= '0;
        end else begin
            stateReg    <= stateNext;
            timerReg    <= timerNext;
            drainCntReg <= drainCntNext;
            byte0Reg    <= byte0Next;
            byte1Reg    <= byte1Next;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        timerNext      = timerReg;
        drainCntNext   = drainCntReg;
        byte0Next      = byte0Reg;
        byte1Next      = byte1Reg;
        ADT7310CS_n_o  = 1'b1;
        SPI_Data_o     = '0;
        SPI_Write_o    = 1'b0;
        SPI_ReadNext_o = 1'b0;
        Done_o         = 1'b0;

        case (stateReg)
            stIdle: begin
                if (Start_i) stateNext = stWrCfg0;
            end
            // Push states hold their byte until the TX FIFO has room, keeping order intact.
            stWrCfg0: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Data_o    = CmdWrCfg;
                if (!SPI_FIFOFull_i) begin
                    SPI_Write_o = 1'b1;
                    stateNext   = stWrCfg1;
                end
            end
            stWrCfg1: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Data_o    = CfgOneShot;
                if (!SPI_FIFOFull_i) begin
                    SPI_Write_o = 1'b1;
                    stateNext   = stWaitCfg;
                end
            end
            stWaitCfg: begin
                ADT7310CS_n_o = 1'b0;
                if (!SPI_Transmission_i) begin
                    stateNext    = stDrainCfg;
                    timerNext    = ParamCounterPreset_i;
                    drainCntNext = 1'b0;
                end
            end
            // Two dummy bytes came back during the config write; discard them.
            stDrainCfg: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    if (drainCntReg) stateNext = stConv;
                    else             drainCntNext = 1'b1;
                end
            end
            stConv: begin
                if (timerReg == '0) stateNext = stRd0;
                else                timerNext = timerReg - 1'b1;
            end
            stRd0: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Data_o    = CmdRdTemp;
                if (!SPI_FIFOFull_i) begin
                    SPI_Write_o = 1'b1;
                    stateNext   = stRd1;
                end
            end
            stRd1: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Data_o    = '1;
                if (!SPI_FIFOFull_i) begin
                    SPI_Write_o = 1'b1;
                    stateNext   = stRd2;
                end
            end
            stRd2: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Data_o    = '1;
                if (!SPI_FIFOFull_i) begin
                    SPI_Write_o = 1'b1;
                    stateNext   = stWaitRd;
                end
            end
            stWaitRd: begin
                ADT7310CS_n_o = 1'b0;
                if (!SPI_Transmission_i) stateNext = stPop0;
            end
            stPop0: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    stateNext      = stPop1;
                end
            end
            stPop1: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    byte1Next      = SPI_Data_i;
                    stateNext      = stPop2;
                end
            end
            stPop2: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    byte0Next      = SPI_Data_i;
                    stateNext      = stDone;
                end
            end
            stDone: begin
                Done_o    = 1'b1;
                stateNext = stIdle;
            end
            default: stateNext = stIdle;
        endcase
    end

    assign Byte0_o = byte0Reg;
    assign Byte1_o = byte1Reg;

endmodule

// File: tb/tb_adt7310_measure_fsm.sv
// Scoreboard bench for adt7310_measure_fsm with a simple SPI master/FIFO model.
module tb_adt7310_measure_fsm;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Done;
    logic [7:0]  Byte0, Byte1;
    logic [15:0] Preset = 16'd0;
    logic        CS_n;
    logic [7:0]  SpiDataOut;
    logic        SpiWrite, SpiReadNext;
    logic [7:0]  SpiDataIn;
    logic        SpiFull, SpiEmpty, SpiTrans;

    logic        fullForce = 1'b0, emptyForce = 1'b0, holdTrans = 1'b0;
    logic        rxEmptyM = 1'b1;
    logic [7:0]  rxHeadM = 8'h00;
    logic [7:0]  respq[$];
    logic [7:0]  rxq[$];
    int          popCnt = 0;
    int          cyc = 0;

    assign SpiFull   = fullForce;
    assign SpiEmpty  = rxEmptyM | emptyForce;
    assign SpiDataIn = rxHeadM;
    assign SpiTrans  = SpiWrite | holdTrans;

    adt7310_measure_fsm dut (
        .Clk_i(Clk), .Reset_n_i(Reset_n), .Start_i(Start), .Done_o(Done),
        .Byte0_o(Byte0), .Byte1_o(Byte1), .ParamCounterPreset_i(Preset),
        .ADT7310CS_n_o(CS_n), .SPI_Data_o(SpiDataOut), .SPI_Write_o(SpiWrite),
        .SPI_ReadNext_o(SpiReadNext), .SPI_Data_i(SpiDataIn), .SPI_FIFOFull_i(SpiFull),
        .SPI_FIFOEmpty_i(SpiEmpty), .SPI_Transmission_i(SpiTrans)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Each pushed byte immediately yields one received byte from respq.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rxq.delete();
            rxEmptyM <= 1'b1;
            rxHeadM  <= 8'h00;
        end else begin
            if (SpiReadNext && rxq.size() > 0) begin
                void'(rxq.pop_front());
                popCnt <= popCnt + 1;
            end
            if (SpiWrite) begin
                if (respq.size() > 0) rxq.push_back(respq.pop_front());
                else                  rxq.push_back(8'h00);
            end
            rxEmptyM <= (rxq.size() == 0);
            rxHeadM  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
        end
    end

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b0;
        int         cycAt;
    } done_t;

    logic [7:0] expTx[$];
    done_t      expDone[$];
    int         checks = 0, errors = 0;
    bit         csHighSeen = 1'b1;
    int         startCyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every push and every Done pulse against the scoreboard.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (SpiWrite) begin
                check("cs_low_on_push", {31'd0, CS_n}, 32'd0);
                if (expTx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_push: got %02h expected none", SpiDataOut);
                end else begin
                    check("push_byte", {24'd0, SpiDataOut}, {24'd0, expTx.pop_front()});
                end
                if (SpiDataOut == 8'h20) csHighSeen = 1'b0;
                if (SpiDataOut == 8'h50) check("cs_gap", {31'd0, csHighSeen}, 32'd1);
            end
            if (CS_n) csHighSeen = 1'b1;
            if (Done) begin
                if (expDone.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
                end else begin
                    done_t e;
                    e = expDone.pop_front();
                    check("byte1", {24'd0, Byte1}, {24'd0, e.b1});
                    check("byte0", {24'd0, Byte0}, {24'd0, e.b0});
                    check("done_cycle", cyc, e.cycAt);
                end
            end
        end
    end

    // extra = stall cycles added on top of the ideal P+14 latency (sample edge counted as 1).
    task automatic startMeasure(input logic [15:0] p, input logic [7:0] b1, input logic [7:0] b0,
                                input int extra);
        Preset = p;
        respq  = {8'h00, 8'h00, 8'h00, b1, b0};
        expTx.push_back(8'h08); expTx.push_back(8'h20);
        expTx.push_back(8'h50); expTx.push_back(8'hFF); expTx.push_back(8'hFF);
        @(negedge Clk); Start = 1'b1;
        @(posedge Clk); #1 Start = 1'b0;
        startCyc = cyc;
        expDone.push_back('{b1, b0, startCyc + int'(p) + 13 + extra});
    endtask

    task automatic waitIdle();
        int n = 0;
        while (expDone.size() != 0 && n < 300) begin
            @(negedge Clk); n++;
        end
        if (expDone.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no Done after %0d cycles expected Done", n);
            expDone.delete();
        end
        check("tx_all_pushed", expTx.size(), 32'd0);
        expTx.delete();
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        int n;
        int base;
        // 1: reset held, Start toggling, nothing happens
        repeat (4) begin
            @(negedge Clk); Start = ~Start;
            check("rst_cs", {31'd0, CS_n}, 32'd1);
            check("rst_done", {31'd0, Done}, 32'd0);
            check("rst_write", {31'd0, SpiWrite}, 32'd0);
        end
        Start = 1'b0;
        @(negedge Clk); Reset_n = 1'b1;
        check("rst_byte0", {24'd0, Byte0}, 32'd0);
        check("rst_byte1", {24'd0, Byte1}, 32'd0);
        check("rst_spidata", {24'd0, SpiDataOut}, 32'd0);
        check("rst_readnext", {31'd0, SpiReadNext}, 32'd0);
        repeat (5) begin
            @(negedge Clk);
            check("idle_cs", {31'd0, CS_n}, 32'd1);
        end

        // 2: preset 5, normal cycle
        startMeasure(16'd5, 8'h0C, 8'h80, 0);
        waitIdle();
        check("hold_byte1", {24'd0, Byte1}, 32'h0C);

        // 3: preset 0, one cycle in stConv
        startMeasure(16'd0, 8'h19, 8'hA0, 0);
        waitIdle();

        // 4: TX FIFO full for 3 cycles during stRd1
        startMeasure(16'd3, 8'h12, 8'h34, 3);
        n = 0;
        while (!(SpiWrite && SpiDataOut == 8'h50) && n < 200) begin @(negedge Clk); n++; end
        check("found_rd0", {31'd0, SpiWrite}, 32'd1);
        @(posedge Clk); #1 fullForce = 1'b1; holdTrans = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("full_no_write", {31'd0, SpiWrite}, 32'd0);
            @(posedge Clk);
        end
        #1 fullForce = 1'b0; holdTrans = 1'b0;
        waitIdle();

        // 5: RX FIFO empty for 4 cycles during stPop1
        startMeasure(16'd2, 8'hAB, 8'hCD, 4);
        base = popCnt;
        n = 0;
        while (!((popCnt - base) == 2 && SpiReadNext) && n < 200) begin @(negedge Clk); n++; end
        check("found_pop0", {31'd0, SpiReadNext}, 32'd1);
        @(posedge Clk); #1 emptyForce = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            check("empty_no_pop", {31'd0, SpiReadNext}, 32'd0);
            check("empty_byte1_held", {24'd0, Byte1}, 32'h12);
            @(posedge Clk);
        end
        #1 emptyForce = 1'b0;
        waitIdle();

        // 6: reset during stConv aborts; then a full sequence runs again
        startMeasure(16'd20, 8'h55, 8'h66, 0);
        base = popCnt;
        n = 0;
        while ((popCnt - base) != 2 && n < 200) begin @(negedge Clk); n++; end
        repeat (5) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1 check("abort_cs", {31'd0, CS_n}, 32'd1);
        check("abort_done", {31'd0, Done}, 32'd0);
        expTx.delete(); expDone.delete(); respq.delete();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (30) begin
            @(negedge Clk);
            check("post_abort_idle_cs", {31'd0, CS_n}, 32'd1);
        end
        startMeasure(16'd1, 8'h0F, 8'hF0, 0);
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
